// File: rtl/pulse_gate_sched.sv
// Shared pulse-line scheduler: per-channel first-trigger inhibit, round-robin grant
// of pending requests, single-cycle tagged output pulse followed by a holdoff gap.
module pulse_gate_sched #(
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int HOLD_W = 8
) (
    input  logic              CLK,
    input  logic              R,
    input  logic [N_CH-1:0]   ARM,
    input  logic [N_CH-1:0]   TRG,
    input  logic [HOLD_W-1:0] HOLDOFF,
    output logic              POUT,
    output logic [CH_W-1:0]   PCH,
    output logic              BUSY,
    output logic [N_CH-1:0]   ACT,
    output logic [N_CH-1:0]   DROP
);

    typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

    state_t              state_q;
    logic [N_CH-1:0]     act_q, act_d;
    logic [N_CH-1:0]     pend_q, pend_d;
    logic [N_CH-1:0]     drop_q, drop_d;
    logic [N_CH-1:0]     grant;
    logic [CH_W-1:0]     lp_q, pch_q;
    logic [CH_W-1:0]     gnt_ch, ch_hi, ch_lo;
    logic                found_hi, found_lo, gnt_valid;
    logic [HOLD_W-1:0]   cnt_q;
    logic                pout_q;

    // Round-robin: prefer the lowest pending channel above lp, else wrap to the lowest one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        ch_hi    = '0;
        ch_lo    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pend_q[i] && (CH_W'(i) > lp_q) && !found_hi) begin
                found_hi = 1'b1;
                ch_hi    = CH_W'(i);
            end
            if (pend_q[i] && (CH_W'(i) <= lp_q) && !found_lo) begin
                found_lo = 1'b1;
                ch_lo    = CH_W'(i);
            end
        end
        gnt_ch    = found_hi ? ch_hi : ch_lo;
        gnt_valid = (state_q == IDLE) && (found_hi || found_lo);
        grant     = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = gnt_valid && (gnt_ch == CH_W'(i));
        end
    end

    // A trigger that lands on the channel being granted re-requests instead of dropping.
    always_comb begin
        act_d  = act_q;
        pend_d = pend_q;
        drop_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!ARM[i]) begin
                act_d[i]  = 1'b0;
                pend_d[i] = 1'b0;
            end else if (TRG[i]) begin
                if (!act_q[i]) begin
                    act_d[i] = 1'b1;
                end else if (!pend_q[i]) begin
                    pend_d[i] = 1'b1;
                end else if (!grant[i]) begin
                    drop_d[i] = 1'b1;
                end
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            act_q   <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            pout_q  <= 1'b0;
            pch_q   <= '0;
            lp_q    <= CH_W'(N_CH - 1);
            cnt_q   <= '0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        pch_q   <= gnt_ch;
                        lp_q    <= gnt_ch;
                        pout_q  <= 1'b1;
                        state_q <= FIRE;
                    end
                end
                FIRE: begin
                    pout_q  <= 1'b0;
                    cnt_q   <= HOLDOFF;
                    state_q <= (HOLDOFF == '0) ? IDLE : HOLD;
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - HOLD_W'(1);
                    end
                    if (cnt_q <= HOLD_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    pout_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign POUT = pout_q;
    assign PCH  = pch_q;
    assign BUSY = (state_q != IDLE);
    assign ACT  = act_q;
    assign DROP = drop_q;

endmodule

// File: tb/tb_pulse_gate_sched.sv
// Bench for pulse_gate_sched: expected pulses (channel, cycle) are queued when
// triggers are driven and matched against every observed output pulse.
module tb_pulse_gate_sched;

    logic       CLK;
    logic       R;
    logic [3:0] ARM;
    logic [3:0] TRG;
    logic [7:0] HOLDOFF;
    logic       POUT;
    logic [1:0] PCH;
    logic       BUSY;
    logic [3:0] ACT;
    logic [3:0] DROP;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t sbQ[$];
    exp_t popped;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m;

    pulse_gate_sched #(.N_CH(4), .CH_W(2), .HOLD_W(8)) dut (
        .CLK(CLK), .R(R), .ARM(ARM), .TRG(TRG), .HOLDOFF(HOLDOFF),
        .POUT(POUT), .PCH(PCH), .BUSY(BUSY), .ACT(ACT), .DROP(DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every observed pulse must match the oldest queued expectation in channel and cycle.
    always @(negedge CLK) begin
        if (R === 1'b1 && POUT === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("pout_unexpected", 32'(POUT), 32'd0);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("pulse_ch", 32'(PCH), 32'(popped.ch));
                checkOutput("pulse_cycle", 32'(cyc), 32'(popped.cyc));
                checkOutput("busy_in_fire", 32'(BUSY), 32'd1);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] arm, input logic [3:0] trg);
        ARM = arm;
        TRG = trg;
        @(negedge CLK);
        TRG = 4'b0000;
    endtask

    task automatic expectPulse(input int ch, input int at);
        sbQ.push_back('{ch: ch, cyc: at});
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 80) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 80) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("idle_wait", 32'(BUSY), 32'd0);
        @(negedge CLK);
    endtask

    task automatic doReset();
        R   = 1'b0;
        ARM = 4'b0000;
        TRG = 4'b0000;
        repeat (2) @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        R       = 1'b0;
        ARM     = 4'b0000;
        TRG     = 4'b0000;
        HOLDOFF = 8'd0;
        #3;
        checkOutput("rst_pout", 32'(POUT), 32'd0);
        checkOutput("rst_pch", 32'(PCH), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_act", 32'(ACT), 32'd0);
        checkOutput("rst_drop", 32'(DROP), 32'd0);
        @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);

        // First trigger after arming is swallowed; later ones pulse two cycles on.
        HOLDOFF = 8'd0;
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("s1_act0", 32'(ACT), 32'h1);
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            m = cyc;
            expectPulse(0, m + 2);
            applyStimulus(4'b0001, 4'b0001);
            repeat (3) @(negedge CLK);
        end
        waitDrain();
        waitIdle();

        // Simultaneous requests from reset priority: 0,1,2,3 spaced HOLDOFF+2.
        doReset();
        HOLDOFF = 8'd2;
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("s2_act_all", 32'(ACT), 32'hF);
        m = cyc;
        for (int k = 0; k < 4; k++) expectPulse(k, m + 2 + 4 * k);
        applyStimulus(4'b1111, 4'b1111);
        waitDrain();
        waitIdle();

        // Retriggers during a long holdoff: one request is held, the next drops.
        HOLDOFF = 8'd10;
        applyStimulus(4'b0100, 4'b0000);
        m = cyc;
        expectPulse(2, m + 2);
        applyStimulus(4'b0100, 4'b0100);
        repeat (3) @(negedge CLK);
        expectPulse(2, m + 14);
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("s3_drop_none", 32'(DROP), 32'h0);
        repeat (2) @(negedge CLK);
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("s3_drop_set", 32'(DROP), 32'h4);
        @(negedge CLK);
        checkOutput("s3_drop_clear", 32'(DROP), 32'h0);
        waitDrain();
        waitIdle();

        // Two channels retriggering every cycle must alternate.
        HOLDOFF = 8'd1;
        applyStimulus(4'b0011, 4'b0011);
        checkOutput("s4_act", 32'(ACT), 32'h3);
        m = cyc;
        for (int k = 0; k < 6; k++) expectPulse(k % 2, m + 2 + 3 * k);
        ARM = 4'b0011;
        TRG = 4'b0011;
        repeat (12) @(negedge CLK);
        TRG = 4'b0000;
        waitDrain();
        waitIdle();

        // Disarming a pending channel during holdoff cancels it; re-arm re-inhibits.
        HOLDOFF = 8'd10;
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b1001, 4'b1001);
        checkOutput("s5_act", 32'(ACT), 32'h9);
        m = cyc;
        expectPulse(0, m + 2);
        applyStimulus(4'b1001, 4'b0001);
        repeat (3) @(negedge CLK);
        applyStimulus(4'b1001, 4'b1000);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("s5_act3_clear", 32'(ACT), 32'h1);
        applyStimulus(4'b1001, 4'b0000);
        waitDrain();
        waitIdle();
        repeat (4) @(negedge CLK);
        applyStimulus(4'b1001, 4'b1000);
        checkOutput("s5_act3_rearm", 32'(ACT), 32'h9);
        repeat (4) @(negedge CLK);
        m = cyc;
        expectPulse(3, m + 2);
        applyStimulus(4'b1001, 4'b1000);
        waitDrain();
        waitIdle();

        // Asynchronous reset in the middle of a FIRE cycle.
        HOLDOFF = 8'd0;
        applyStimulus(4'b0010, 4'b0010);
        m = cyc;
        expectPulse(1, m + 2);
        applyStimulus(4'b0010, 4'b0010);
        @(negedge CLK);
        #2;
        R = 1'b0;
        #1;
        checkOutput("s6_pout", 32'(POUT), 32'd0);
        checkOutput("s6_busy", 32'(BUSY), 32'd0);
        checkOutput("s6_act", 32'(ACT), 32'h0);
        checkOutput("s6_drop", 32'(DROP), 32'h0);
        checkOutput("s6_pch", 32'(PCH), 32'd0);
        checkOutput("s6_sb_empty", 32'(sbQ.size()), 32'd0);
        @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
        applyStimulus(4'b1111, 4'b1111);
        m = cyc;
        expectPulse(0, m + 2);
        expectPulse(1, m + 4);
        applyStimulus(4'b1111, 4'b0011);
        waitDrain();
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
